gene_prune_ctrl: RTL and testbench
==================================

# gene_prune_ctrl

Sequencer and arbiter in front of the PE's deleted-node table. Accepts gene records from NUM_REQ requesters (parent genome streams) with round-robin arbitration and records node genes marked for deletion. It drops connection genes whose endpoints reference a deleted node and forwards every surviving gene downstream over a valid/ready handshake.

## Interface
- DATA_WIDTH, 8, node ID width
- MAX_DEL, 8, deleted-node table entries
- NUM_REQ, 2, requester count (≥2); SRC_W = $clog2(NUM_REQ)
- clk  input  1  sole clock, rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- req_valid  input  NUM_REQ  per-requester gene valid
- req_ready  output  NUM_REQ  per-requester accept (one-hot or zero)
- req_conn  input  NUM_REQ  1 = connection gene, 0 = node gene
- req_del  input  NUM_REQ  node gene marked for deletion (ignored when conn=1)
- req_id1  input  NUM_REQ*DATA_WIDTH  node ID / connection source, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_id2  input  NUM_REQ*DATA_WIDTH  connection destination (ignored for node genes)
- flush  input  1  clear table, count and overflow
- out_valid  output  1  forwarded gene valid
- out_ready  input  1  downstream accept
- out_conn, out_id1, out_id2  output  1/DATA_WIDTH/DATA_WIDTH  forwarded gene
- out_src  output  SRC_W  requester index of forwarded gene
- full  output  1  table holds MAX_DEL entries
- overflow  output  1  sticky; delete request arrived while full
- drop_cnt  output  16  connection genes dropped, saturating

## Operation
- FSM states: IDLE, LOOKUP, SEND.
- IDLE: winner = first requester with req_valid set, searching from rr_ptr upward with wrap. req_ready[winner]=1 combinationally. Transfer completes when valid&ready. On transfer: latch gene and winner index, set rr_ptr = winner+1 (mod NUM_REQ), go LOOKUP. No valid requester: stay in IDLE, req_ready=0.
- LOOKUP (one cycle, req_ready=0). Only valid entries participate in matching:
  - Node gene, del=1, not full: write id1 into entry[count], set valid, increment count, go IDLE. Duplicate IDs are stored again.
  - Node gene, del=1, full: set overflow, discard gene, go IDLE.
  - Node gene, del=0: go SEND.
  - Conn gene, id1 or id2 matches a valid entry: drop gene, increment drop_cnt (saturates at 0xFFFF), go IDLE.
  - Conn gene, no match: go SEND.
- SEND: out_valid=1 with registered out_* fields. Advance to IDLE on out_ready. Fields hold stable while stalled.
- full = (count == MAX_DEL), registered.
- flush, any state: on the next edge, clear all valid bits, count, full and overflow. State, rr_ptr and drop_cnt are untouched.
  - flush in the same cycle as a LOOKUP write: flush wins and the write is lost.
  - LOOKUP match in the flush cycle uses pre-flush contents.
- Reset (any state, mid-transfer included): state IDLE, rr_ptr 0, all entries invalid, count 0. req_ready, out_valid, out_conn, out_id1, out_id2, out_src, full, overflow and drop_cnt all 0. A gene held in LOOKUP or SEND is lost.

## Timing
- Accept-to-table-write: 1 cycle; table updated and visible to the next gene's LOOKUP.
- Accept-to-out_valid: 2 edges (accept edge, then LOOKUP edge).
- Sustained throughput: 1 gene / 2 cycles for deleted or dropped genes. Forwarded genes take 3 cycles plus downstream stall.
- req_ready depends combinationally on req_valid and state; no other combinational input-to-output paths.
- A delete immediately followed by a connection gene referencing it is dropped (no hazard).

## Configuration
- GENE_PRUNE_STATS_EN defined: drop_cnt counter implemented as above.
- Not defined: counter logic removed and drop_cnt tied to 0. All other behaviour identical.

## Structure
- Package gene_prune_pkg holds:
  - the FSM state enum (IDLE/LOOKUP/SEND)
  - the gene record struct (conn, del, id1, id2)
  - the drop_cnt width constant (16)
- Sub-module node_del_table: MAX_DEL-entry valid-tagged CAM.
  - Inputs: write port, flush.
  - Outputs: two parallel match lookups, count, full.
- The arbiter and FSM live in gene_prune_ctrl.

## Test plan
- Delete then prune: req0 node id1=0x05 del=1, then req0 conn 0x05→0x09 → no out_valid, drop_cnt=1. Then conn 0x03→0x04 → forwarded, out_id1=0x03, out_id2=0x04, out_src=0.
- Round-robin: req0 and req1 valid continuously with node del=0 genes → grants alternate 0,1,0,1; out_src alternates accordingly.
- Full/overflow: 8 deletes of IDs 1..8 → full=1 after the 8th LOOKUP. 9th delete (ID 9) → overflow=1. Conn 9→1 dropped (matches 1); conn 9→10 forwarded.
- Back-pressure: out_ready=0 for 5 cycles in SEND → out_valid held, fields stable, req_ready=0 throughout. out_ready=1 → IDLE next edge.
- Flush collision: flush asserted in the LOOKUP cycle of a delete of ID 0x20 → table empty afterwards, and a following conn 0x20→0x21 is forwarded.
- Async reset: drop rst during SEND → out_valid, full, overflow and drop_cnt 0 immediately. After release, an earlier-deleted ID no longer matches.

Source files
------------

// File: rtl/gene_prune_pkg.sv
// -----------------------------------------------------------------------------
// gene_prune_pkg
//   Shared types and constants for the gene pruning front end.
//   - state_t    : sequencer states (IDLE / LOOKUP / SEND)
//   - gene_t     : one gene record as latched from a requester
//   - DROP_CNT_W : width of the dropped-connection counter
//   - sat_inc    : saturating increment used by the drop counter
//   The optional statistics counter is controlled by GENE_PRUNE_STATS_EN
//   (see gene_prune_ctrl).
// -----------------------------------------------------------------------------
package gene_prune_pkg;

    // Node ID width carried in gene_t; the top-level DATA_WIDTH must match.
    localparam int GENE_ID_W  = 8;
    localparam int DROP_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        SEND   = 2'd2
    } state_t;

    typedef struct packed {
        logic                 conn;  // 1 = connection gene, 0 = node gene
        logic                 del;   // node gene marked for deletion
        logic [GENE_ID_W-1:0] id1;   // node ID / connection source
        logic [GENE_ID_W-1:0] id2;   // connection destination
    } gene_t;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/node_del_table.sv
// -----------------------------------------------------------------------------
// node_del_table
//   MAX_DEL-entry, valid-tagged CAM of deleted node IDs. Entries are filled
//   in order (entry[count]); duplicates are stored again. Two independent
//   match ports let a connection gene check source and destination at once.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   wr_en, wr_id        append wr_id when set (ignored when full)
//   flush               clear all valid bits, count and full (beats wr_en)
//   lookup_a/lookup_b   IDs to match against valid entries
//   match_a/match_b     combinational match results (pre-update contents)
//   count               number of valid entries
//   full                registered, count == MAX_DEL
// -----------------------------------------------------------------------------
module node_del_table #(
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_DEL    = 8,
    localparam int CNT_W      = $clog2(MAX_DEL + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_id,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] lookup_a,
    input  logic [DATA_WIDTH-1:0] lookup_b,
    output logic                  match_a,
    output logic                  match_b,
    output logic [CNT_W-1:0]      count,
    output logic                  full
);

    logic [DATA_WIDTH-1:0] ids [MAX_DEL];
    logic [MAX_DEL-1:0]    valid;
    logic                  wr_ok;

    assign wr_ok = wr_en && !full && !flush;

    // NOTE: sequential state is always written with non-blocking assignments
    // so every register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            count <= '0;
            full  <= 1'b0;
        end else if (flush) begin
            valid <= '0;
            count <= '0;
            full  <= 1'b0;
        end else if (wr_ok) begin
            for (int i = 0; i < MAX_DEL; i++) begin
                if (count == CNT_W'(i)) begin
                    valid[i] <= 1'b1;
                end
            end
            count <= count + 1'b1;
            full  <= (count == CNT_W'(MAX_DEL - 1));
        end
    end

    // NOTE: the ID storage has no reset; an entry is only ever observed
    // through its valid bit, which is reset, so the data needs no clearing.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int i = 0; i < MAX_DEL; i++) begin
                if (count == CNT_W'(i)) begin
                    ids[i] <= wr_id;
                end
            end
        end
    end

    // NOTE: every variable driven here gets a default before the loop;
    // otherwise a path that skips the assignment would infer a latch.
    always_comb begin
        match_a = 1'b0;
        match_b = 1'b0;
        for (int i = 0; i < MAX_DEL; i++) begin
            if (valid[i] && (ids[i] == lookup_a)) match_a = 1'b1;
            if (valid[i] && (ids[i] == lookup_b)) match_b = 1'b1;
        end
    end

endmodule

// File: rtl/gene_prune_ctrl.sv
// -----------------------------------------------------------------------------
// gene_prune_ctrl
//   Round-robin arbiter + sequencer in front of the deleted-node table.
//   Node genes marked for deletion are recorded in the table; connection
//   genes touching a deleted node are dropped; everything else is forwarded
//   on a valid/ready output.
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   req_valid/req_ready           per-requester handshake (ready one-hot/0)
//   req_conn/req_del              gene kind / delete mark per requester
//   req_id1/req_id2               packed IDs, requester i at [i*DW +: DW]
//   flush                         clear table, count, full and overflow
//   out_valid/out_ready           forwarded-gene handshake
//   out_conn/out_id1/out_id2      forwarded gene fields (registered)
//   out_src                       requester index of forwarded gene
//   full                          table holds MAX_DEL entries
//   overflow                      sticky: delete arrived while full
//   drop_cnt                      dropped connection genes, saturating
//
// Configuration
//   GENE_PRUNE_STATS_EN defined   : drop_cnt counter implemented
//   GENE_PRUNE_STATS_EN undefined : drop_cnt tied to zero
// -----------------------------------------------------------------------------
module gene_prune_ctrl
    import gene_prune_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_DEL    = 8,
    parameter  int NUM_REQ    = 2,
    localparam int SRC_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_conn,
    input  logic [NUM_REQ-1:0]            req_del,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_id1,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_id2,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_conn,
    output logic [DATA_WIDTH-1:0]         out_id1,
    output logic [DATA_WIDTH-1:0]         out_id2,
    output logic [SRC_W-1:0]              out_src,
    output logic                          full,
    output logic                          overflow,
    output logic [DROP_CNT_W-1:0]         drop_cnt
);

    localparam int CNT_W = $clog2(MAX_DEL + 1);

    state_t             state, state_nxt;
    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   winner;
    logic [SRC_W-1:0]   src_q;
    logic               found;
    logic               accept;
    int                 arb_idx;
    gene_t              gene_q;

    logic               match_a, match_b;
    logic [CNT_W-1:0]   del_count;
    logic               table_full_now;
    logic               is_del;
    logic               hit;
    logic               tbl_wr;
    logic               ovf_set;

    // ------------------------------------------------------------------
    // Round-robin arbiter: scan offsets from rr_ptr with wrap. The loop
    // runs from the farthest offset down so the closest valid requester
    // is the last (and winning) assignment.
    // ------------------------------------------------------------------
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        arb_idx = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            arb_idx = int'(rr_ptr) + k;
            if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
            if (req_valid[arb_idx]) begin
                found  = 1'b1;
                winner = SRC_W'(arb_idx);
            end
        end
    end

    // Ready is raised only for the winner, so a grant is always a transfer.
    assign accept = (state == IDLE) && found;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[winner] = 1'b1;
    end

    // ------------------------------------------------------------------
    // Deleted-node table
    // ------------------------------------------------------------------
    node_del_table #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_DEL    (MAX_DEL)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (tbl_wr),
        .wr_id    (gene_q.id1),
        .flush    (flush),
        .lookup_a (gene_q.id1),
        .lookup_b (gene_q.id2),
        .match_a  (match_a),
        .match_b  (match_b),
        .count    (del_count),
        .full     (full)
    );

    // ------------------------------------------------------------------
    // LOOKUP decode. Matching sees the table as it was before this edge,
    // so a flush in the same cycle still lets the current gene match.
    // ------------------------------------------------------------------
    assign table_full_now = (del_count == CNT_W'(MAX_DEL));
    assign is_del         = (state == LOOKUP) && !gene_q.conn && gene_q.del;
    assign hit            = gene_q.conn && (match_a || match_b);
    assign tbl_wr         = is_del && !table_full_now;
    assign ovf_set        = is_del && table_full_now;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LOOKUP;
            LOOKUP:  begin
                if (gene_q.conn) state_nxt = hit ? IDLE : SEND;
                else             state_nxt = gene_q.del ? IDLE : SEND;
            end
            SEND:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            gene_q <= '0;
            src_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                gene_q.conn <= req_conn[winner];
                gene_q.del  <= req_del[winner];
                gene_q.id1  <= req_id1[winner*DATA_WIDTH +: DATA_WIDTH];
                gene_q.id2  <= req_id2[winner*DATA_WIDTH +: DATA_WIDTH];
                src_q       <= winner;
                rr_ptr      <= (winner == SRC_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            end
        end
    end

    // Sticky overflow; flush clears it even if a new overflow lands that cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (flush) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end
    end

`ifdef GENE_PRUNE_STATS_EN
    // flush deliberately leaves this counter alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if ((state == LOOKUP) && hit) begin
            drop_cnt <= sat_inc(drop_cnt);
        end
    end
`else
    assign drop_cnt = '0;
`endif

    // The output fields are the latched gene itself; they only change on a
    // new accept, which cannot happen while SEND is stalled.
    assign out_valid = (state == SEND);
    assign out_conn  = gene_q.conn;
    assign out_id1   = gene_q.id1;
    assign out_id2   = gene_q.id2;
    assign out_src   = src_q;

endmodule

// File: tb/tb_gene_prune_ctrl.sv
`timescale 1ns/1ps
module tb_gene_prune_ctrl;

    localparam int DW = 8;
    localparam int MD = 8;
    localparam int NR = 2;
    localparam int SW = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     req_conn = '0;
    logic [NR-1:0]     req_del = '0;
    logic [NR*DW-1:0]  req_id1 = '0;
    logic [NR*DW-1:0]  req_id2 = '0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_conn;
    logic [DW-1:0]     out_id1;
    logic [DW-1:0]     out_id2;
    logic [SW-1:0]     out_src;
    logic              full;
    logic              overflow;
    logic [15:0]       drop_cnt;

    gene_prune_ctrl #(.DATA_WIDTH(DW), .MAX_DEL(MD), .NUM_REQ(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_conn  (req_conn),
        .req_del   (req_del),
        .req_id1   (req_id1),
        .req_id2   (req_id2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_conn  (out_conn),
        .out_id1   (out_id1),
        .out_id2   (out_id2),
        .out_src   (out_src),
        .full      (full),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [DW-1:0] m_list[$];   // deleted IDs in arrival order
    bit            m_ovf;
    int            m_drop;
    int            m_rr;

    function automatic bit m_has(input logic [DW-1:0] id);
        foreach (m_list[i]) if (m_list[i] == id) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int exp_drop();
`ifdef GENE_PRUNE_STATS_EN
        return m_drop;
`else
        return 0;
`endif
    endfunction

    task automatic m_reset();
        m_list.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
        m_rr   = 0;
    endtask

    // Present a gene on requester r (does not clear other requesters).
    task automatic put(input int r, input bit c, input bit d, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_valid[r]         = 1'b1;
        req_conn[r]          = c;
        req_del[r]           = d;
        req_id1[r*DW +: DW]  = a;
        req_id2[r*DW +: DW]  = b;
    endtask

    // Called just after a negedge with requests already driven and the DUT
    // idle. Runs one gene through accept, lookup and (if forwarded) send.
    task automatic run_txn(input bit fl, input int stall);
        int            w;
        int            idx;
        bit            c, d, hit, fwd;
        logic [DW-1:0] a, b;
        w = -1;
        for (int k = 0; k < NR; k++) begin
            idx = (m_rr + k) % NR;
            if (w < 0 && req_valid[idx]) w = idx;
        end
        if (w < 0) w = 0;
        c = req_conn[w];
        d = req_del[w];
        a = req_id1[w*DW +: DW];
        b = req_id2[w*DW +: DW];
        #1 check("grant", 32'(req_ready), 32'(1 << w));
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        flush     = fl;
        m_rr = (w + 1) % NR;
        hit  = c && (m_has(a) || m_has(b));
        fwd  = c ? !hit : !d;
        if (!c && d && !fl) begin
            if (m_list.size() < MD) m_list.push_back(a);
            else                    m_ovf = 1'b1;
        end
        if (hit && m_drop < 65535) m_drop++;
        if (fl) begin
            m_list.delete();
            m_ovf = 1'b0;
        end
        #1 check("lookup_outv", 32'(out_valid), 0);
        check("lookup_ready", 32'(req_ready), 0);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        #1 check("outv", 32'(out_valid), 32'(fwd));
        check("full", 32'(full), 32'(m_list.size() == MD));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("drop_cnt", 32'(drop_cnt), 32'(exp_drop()));
        if (fwd) begin
            for (int s = 0; s <= stall; s++) begin
                if (s > 0) begin
                    @(posedge clk);
                    @(negedge clk);
                    #1 check("stall_outv", 32'(out_valid), 1);
                end
                check("out_conn", 32'(out_conn), 32'(c));
                check("out_id1", 32'(out_id1), 32'(a));
                check("out_id2", 32'(out_id2), 32'(b));
                check("out_src", 32'(out_src), 32'(w));
                check("send_ready", 32'(req_ready), 0);
            end
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
            #1 check("send_exit", 32'(out_valid), 0);
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        m_list.delete();
        m_ovf = 1'b0;
        #1 check("flush_full", 32'(full), 0);
        check("flush_ovf", 32'(overflow), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        #2;
        check("rst_outv", 32'(out_valid), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_full", 32'(full), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_drop", 32'(drop_cnt), 0);
        check("rst_src", 32'(out_src), 0);
        @(negedge clk);
        rst = 1'b1;
        #1 check("idle_ready", 32'(req_ready), 0);

        // Delete then prune, then forward an unrelated connection.
        put(0, 1'b0, 1'b1, 8'h05, 8'h00); run_txn(1'b0, 0);
        put(0, 1'b1, 1'b0, 8'h05, 8'h09); run_txn(1'b0, 0);
        put(0, 1'b1, 1'b0, 8'h03, 8'h04); run_txn(1'b0, 2);

        // Round-robin with both requesters valid.
        for (int i = 0; i < 4; i++) begin
            put(0, 1'b0, 1'b0, 8'(i), 8'h00);
            put(1, 1'b0, 1'b0, 8'(i + 16), 8'h00);
            run_txn(1'b0, 0);
        end

        // Full / overflow, then back-pressure on a forwarded gene.
        do_flush();
        for (int i = 1; i <= 8; i++) begin
            put(0, 1'b0, 1'b1, 8'(i), 8'h00); run_txn(1'b0, 0);
        end
        put(1, 1'b0, 1'b1, 8'h09, 8'h00); run_txn(1'b0, 0);
        put(0, 1'b1, 1'b0, 8'h09, 8'h01); run_txn(1'b0, 0);
        put(1, 1'b1, 1'b0, 8'h09, 8'h0A); run_txn(1'b0, 5);

        // Async reset while in SEND (table full, overflow set).
        put(0, 1'b1, 1'b0, 8'h40, 8'h41);
        #1 check("arst_grant", 32'(req_ready), 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        #1 check("arst_send", 32'(out_valid), 1);
        #2 rst = 1'b0;
        #1 check("arst_outv", 32'(out_valid), 0);
        check("arst_full", 32'(full), 0);
        check("arst_ovf", 32'(overflow), 0);
        check("arst_drop", 32'(drop_cnt), 0);
        check("arst_id1", 32'(out_id1), 0);
        check("arst_ready", 32'(req_ready), 0);
        @(negedge clk);
        rst = 1'b1;
        m_reset();
        put(0, 1'b1, 1'b0, 8'h01, 8'h02); run_txn(1'b0, 0);

        // Flush colliding with a delete's LOOKUP cycle.
        put(0, 1'b0, 1'b1, 8'h20, 8'h00); run_txn(1'b1, 0);
        put(0, 1'b1, 1'b0, 8'h20, 8'h21); run_txn(1'b0, 0);

        // Randomized traffic.
        for (int t = 0; t < 300; t++) begin
            int mask;
            req_valid = '0;
            mask = $urandom_range(1, 3);
            for (int r = 0; r < NR; r++) begin
                if (mask[r]) put(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 60),
                                 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)));
            end
            run_txn($urandom_range(0, 14) == 0, $urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) do_flush();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
